// File: rtl/uart_frame_loader.sv
// UART-to-SDRAM write stage: pairs received bytes little-endian into 16-bit words and
// queues them with sequential word addresses; tracks frame load progress.
module uart_frame_loader #(
  parameter int WORDS   = 19222,
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 65536,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  input  logic              busy,
  input  logic              clr_overflow,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_enable,
  output logic              loading,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic                 r_phase;
  logic [7:0]           r_low;
  logic [ADDR_W-1:0]    r_wcnt;
  logic [IDLE_W-1:0]    r_idle;
  logic [ADDR_W+15:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wptr, r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_done, r_abort, r_ovf;

  logic                 w_push_req, w_push, w_pop, w_full, w_drop;
  logic                 w_counting, w_timeout, w_last, w_phase_next, w_done_set;
  logic [CNT_W-1:0]     w_count_next;
  logic [ADDR_W+15:0]   w_head;

  // Write handshake: head is valid while the FIFO holds a word; it is consumed in any
  // cycle where wr_enable=1 and busy=0, and held unchanged otherwise.
  assign wr_enable    = (r_count != '0);
  assign w_pop        = wr_enable & ~busy;
  assign w_full       = (r_count == FULL_CNT);
  assign w_push_req   = rx_dv & r_phase;
  assign w_push       = w_push_req & (~w_full | w_pop);
  assign w_drop       = w_push_req & w_full & ~w_pop;
  assign w_last       = w_push_req & (r_wcnt == LAST_ADDR);
  assign w_counting   = (r_state == S_LOAD) | r_phase;
  assign w_timeout    = w_counting & ~rx_dv & (r_idle == IDLE_LAST);
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_phase_next = rx_dv ? ~r_phase : (w_timeout ? 1'b0 : r_phase);

  assign w_head      = r_mem[r_rptr];
  assign wr_addr     = wr_enable ? w_head[ADDR_W+15:16] : '0;
  assign wr_data     = wr_enable ? w_head[15:0] : '0;
  assign loading     = (r_state != S_IDLE);
  assign frame_done  = r_done;
  assign frame_abort = r_abort;
  assign overflow    = r_ovf;
  assign dbg_state   = r_state;

  always_comb begin
    w_state_next = r_state;
    w_done_set   = 1'b0;
    if (w_timeout) begin
      // An abort during DRAIN must not lose the already completed frame.
      w_state_next = (r_state == S_DRAIN) ? S_DRAIN : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (rx_dv) w_state_next = S_LOAD;
        S_LOAD:  if (w_last) w_state_next = S_DRAIN;
        S_DRAIN: begin
          if (w_count_next == '0) begin
            w_done_set   = 1'b1;
            w_state_next = w_phase_next ? S_LOAD : S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_set;
      r_abort <= w_timeout;
      if (w_drop)            r_ovf <= 1'b1;
      else if (clr_overflow) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 1'b0;
      r_low   <= '0;
      r_wcnt  <= '0;
      r_idle  <= '0;
    end else begin
      r_phase <= w_phase_next;
      if (rx_dv && !r_phase) r_low <= rx_byte;
      // A dropped word still consumes its address so later words stay aligned.
      if (w_timeout)       r_wcnt <= '0;
      else if (w_push_req) r_wcnt <= w_last ? '0 : r_wcnt + 1'b1;
      if (rx_dv || w_timeout || !w_counting) r_idle <= '0;
      else                                   r_idle <= r_idle + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_wcnt, rx_byte, r_low};
  end

endmodule
